// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
//   Shared constants and types for the audio path.
//   AUDIO_W        : default sample width (two's complement)
//   dac_tx_state_t : I2S transmitter sequencing states
// ---------------------------------------------------------------------------
package audio_pkg;

    localparam int unsigned AUDIO_W = 16;

    typedef enum logic [1:0] {
        ALIGN,
        DELAY,
        SHIFT,
        PAD
    } dac_tx_state_t;

endpackage

// File: rtl/audio_dac_tx_if.sv
// ---------------------------------------------------------------------------
// audio_dac_tx_if
//   One-cycle sample strobe from the last effect stage into the DAC sink.
//   valid : one-cycle strobe, no back-pressure
//   data  : signed sample, meaningful while valid=1
//   master modport drives the strobe, slave modport receives it.
// ---------------------------------------------------------------------------
interface audio_dac_tx_if
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W = AUDIO_W
);

    logic              valid;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data);
    modport slave  (input  valid, input  data);

endinterface

// File: rtl/audio_sample_fifo.sv
// ---------------------------------------------------------------------------
// audio_sample_fifo
//   Synchronous sample FIFO between the effect chain and the I2S frame timing.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_data : write request and data
//   i_pop          : read request; o_data shows the head entry
//   o_full/o_empty : status
//   A push while full is accepted only when a pop happens in the same cycle.
//   Pops while empty are ignored (no bypass of a same-cycle push).
// ---------------------------------------------------------------------------
module audio_sample_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W     = AUDIO_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Extra pointer MSB distinguishes full from empty when addresses match.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);
    assign o_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/audio_dac_tx.sv
// ---------------------------------------------------------------------------
// audio_dac_tx
//   Sink of the effect-chain sample stream; serialises samples to the codec
//   DAC over I2S (codec is bus master). Mono: each sample goes out on both
//   the left and right slot.
//   i_clk          : system clock, >= 8x BCLK
//   i_rst_n        : asynchronous active-low reset
//   smp            : sample strobe interface (slave)
//   i_aud_bclk     : codec bit clock (asynchronous)
//   i_aud_daclrck  : codec frame clock, 0=left, 1=right (asynchronous)
//   o_aud_dacdat   : serial DAC data, MSB first
//   o_overflow     : sticky, a sample was dropped on a full FIFO
//   o_underrun     : sticky, a left slot started with the FIFO empty
//   o_underrun_cnt : saturating underrun count, present only when
//                    AUDIO_DAC_TX_UNDERRUN_CNT_EN is defined
// ---------------------------------------------------------------------------
module audio_dac_tx
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W      = AUDIO_W,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    audio_dac_tx_if.slave       smp,
    input  logic                i_aud_bclk,
    input  logic                i_aud_daclrck,
    output logic                o_aud_dacdat,
    output logic                o_overflow,
    output logic                o_underrun
`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
    ,
    output logic [7:0]          o_underrun_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [SYNC_STAGES-1:0] bclk_sync;
    logic [SYNC_STAGES-1:0] lrck_sync;
    logic                   bclk_q;
    logic                   lrck_q;
    logic                   bclk_fall;
    logic                   lrck_fall;
    logic                   lrck_rise;

    dac_tx_state_t          state;
    logic [DATA_W-1:0]      hold;
    logic [DATA_W-1:0]      shreg;
    logic [CNT_W-1:0]       bit_cnt;

    logic                   left_start;
    logic                   right_start;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_W-1:0]      fifo_rdata;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i_aud_bclk};
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], i_aud_daclrck};
            bclk_q    <= bclk_sync[SYNC_STAGES-1];
            lrck_q    <= lrck_sync[SYNC_STAGES-1];
        end
    end

    assign bclk_fall = bclk_q & ~bclk_sync[SYNC_STAGES-1];
    assign lrck_fall = lrck_q & ~lrck_sync[SYNC_STAGES-1];
    assign lrck_rise = ~lrck_q & lrck_sync[SYNC_STAGES-1];

    // Right-slot edges are ignored until a left slot has been seen, so the
    // stream always starts on a left slot.
    assign left_start  = lrck_fall;
    assign right_start = lrck_rise && (state != ALIGN);
    assign fifo_pop    = left_start && !fifo_empty;

    audio_sample_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (smp.valid),
        .i_data  (smp.data),
        .i_pop   (fifo_pop),
        .o_data  (fifo_rdata),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // The LRCK edge coincides with a BCLK fall; that fall is the I2S one-bit
    // delay, so DELAY drives the MSB on the following fall.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ALIGN;
            hold         <= '0;
            shreg        <= '0;
            bit_cnt      <= '0;
            o_aud_dacdat <= 1'b0;
            o_underrun   <= 1'b0;
        end else begin
            if (left_start) begin
                if (!fifo_empty) hold <= fifo_rdata;
                else             o_underrun <= 1'b1;
            end
            if (left_start || right_start) begin
                state        <= DELAY;
                bit_cnt      <= '0;
                o_aud_dacdat <= 1'b0;
            end else if (bclk_fall) begin
                unique case (state)
                    DELAY: begin
                        o_aud_dacdat <= hold[DATA_W-1];
                        shreg        <= {hold[DATA_W-2:0], 1'b0};
                        bit_cnt      <= CNT_W'(1);
                        state        <= SHIFT;
                    end
                    SHIFT: begin
                        o_aud_dacdat <= shreg[DATA_W-1];
                        shreg        <= {shreg[DATA_W-2:0], 1'b0};
                        bit_cnt      <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(DATA_W - 1)) state <= PAD;
                    end
                    ALIGN, PAD: begin
                        o_aud_dacdat <= 1'b0;
                    end
                    default: begin
                        state        <= ALIGN;
                        o_aud_dacdat <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A same-cycle pop frees a slot, so the push is only dropped without one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_overflow <= 1'b0;
        end else if (smp.valid && fifo_full && !fifo_pop) begin
            o_overflow <= 1'b1;
        end
    end

`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_underrun_cnt <= '0;
        end else if (left_start && fifo_empty && (o_underrun_cnt != 8'hFF)) begin
            o_underrun_cnt <= o_underrun_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_audio_dac_tx.sv
// ---------------------------------------------------------------------------
// tb_audio_dac_tx
//   Directed bench for audio_dac_tx. BCLK = i_clk/16; each LRCK half-period
//   (one channel slot) is 32 BCLK. DACDAT is sampled at every BCLK rise, as
//   the codec does: rise 1..16 after the LRCK edge carry the sample MSB first,
//   rise 0 and 17..31 must be zero.
//   Define AUDIO_DAC_TX_UNDERRUN_CNT_EN to also check the underrun counter.
// ---------------------------------------------------------------------------
module tb_audio_dac_tx;
    import audio_pkg::*;

    logic        i_clk       = 1'b0;
    logic        i_rst_n     = 1'b0;
    logic        aud_bclk    = 1'b1;
    logic        aud_daclrck = 1'b1;
    logic        aud_dacdat;
    logic        overflow;
    logic        underrun;
`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
    logic [7:0]  underrun_cnt;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [15:0] t4_vals [6] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004, 16'h5005, 16'h6006};
    logic [31:0] bits;

    always #5 i_clk = ~i_clk;

    audio_dac_tx_if #(.DATA_W(AUDIO_W)) smp_if ();

    audio_dac_tx #(
        .DATA_W      (AUDIO_W),
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .smp            (smp_if.slave),
        .i_aud_bclk     (aud_bclk),
        .i_aud_daclrck  (aud_daclrck),
        .o_aud_dacdat   (aud_dacdat),
        .o_overflow     (overflow),
        .o_underrun     (underrun)
`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
        ,
        .o_underrun_cnt (underrun_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        @(negedge i_clk);
        smp_if.valid = 1'b1;
        smp_if.data  = d;
        @(negedge i_clk);
        smp_if.valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n     = 1'b0;
        aud_bclk    = 1'b1;
        aud_daclrck = 1'b1;
        repeat (4) @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (4) @(negedge i_clk);
    endtask

    // n BCLK periods; optionally change LRCK together with the first fall.
    task automatic run_bits(input bit set_lr, input logic lr, input int n, output logic [31:0] b);
        b = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            aud_bclk = 1'b0;
            if (set_lr && i == 0) aud_daclrck = lr;
            repeat (7) @(negedge i_clk);
            @(negedge i_clk);
            aud_bclk = 1'b1;
            b = {b[30:0], aud_dacdat};
            repeat (7) @(negedge i_clk);
        end
    endtask

    task automatic slot_check(input string tag, input logic lr, input logic [15:0] exp);
        logic [31:0] b;
        run_bits(1'b1, lr, 32, b);
        check_eq({tag, "_data"}, {16'h0, b[30:15]}, {16'h0, exp});
        check_eq({tag, "_pad"}, {16'h0, b[31], b[14:0]}, 32'h0);
    endtask

    initial begin
        smp_if.valid = 1'b0;
        smp_if.data  = '0;

        // T1: single sample on both slots
        do_reset();
        check_eq("rst_dacdat", {31'h0, aud_dacdat}, 32'h0);
        check_eq("rst_overflow", {31'h0, overflow}, 32'h0);
        check_eq("rst_underrun", {31'h0, underrun}, 32'h0);
        push(16'hA5C3);
        slot_check("t1_left", 1'b0, 16'hA5C3);
        slot_check("t1_right", 1'b1, 16'hA5C3);

        // T2: extreme values, no flags
        do_reset();
        push(16'h8000);
        slot_check("t2_f0_left", 1'b0, 16'h8000);
        slot_check("t2_f0_right", 1'b1, 16'h8000);
        push(16'h7FFF);
        slot_check("t2_f1_left", 1'b0, 16'h7FFF);
        slot_check("t2_f1_right", 1'b1, 16'h7FFF);
        check_eq("t2_underrun", {31'h0, underrun}, 32'h0);
        check_eq("t2_overflow", {31'h0, overflow}, 32'h0);

        // T3: starvation repeats the last sample
        do_reset();
        push(16'h1234);
        slot_check("t3_f0_left", 1'b0, 16'h1234);
        slot_check("t3_f0_right", 1'b1, 16'h1234);
        check_eq("t3_underrun_f0", {31'h0, underrun}, 32'h0);
        for (int f = 0; f < 3; f++) begin
            slot_check("t3_rep_left", 1'b0, 16'h1234);
            slot_check("t3_rep_right", 1'b1, 16'h1234);
        end
        check_eq("t3_underrun", {31'h0, underrun}, 32'h1);
`ifdef AUDIO_DAC_TX_UNDERRUN_CNT_EN
        check_eq("t3_underrun_cnt", {24'h0, underrun_cnt}, 32'd3);
`endif

        // T4: overflow keeps the first FIFO_DEPTH samples
        do_reset();
        for (int k = 0; k < 6; k++) push(t4_vals[k]);
        check_eq("t4_overflow", {31'h0, overflow}, 32'h1);
        check_eq("t4_underrun_pre", {31'h0, underrun}, 32'h0);
        for (int k = 0; k < 4; k++) begin
            slot_check("t4_left", 1'b0, t4_vals[k]);
            slot_check("t4_right", 1'b1, t4_vals[k]);
        end
        check_eq("t4_underrun_after4", {31'h0, underrun}, 32'h0);
        slot_check("t4_starved_left", 1'b0, 16'h4004);
        check_eq("t4_underrun_after5", {31'h0, underrun}, 32'h1);
        slot_check("t4_starved_right", 1'b1, 16'h4004);

        // T6: reset in the middle of SHIFT (flags are set at this point)
        push(16'hFFFF);
        run_bits(1'b1, 1'b0, 6, bits);
        check_eq("t6_shift_active", {31'h0, aud_dacdat}, 32'h1);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check_eq("t6_rst_dacdat", {31'h0, aud_dacdat}, 32'h0);
        check_eq("t6_rst_overflow", {31'h0, overflow}, 32'h0);
        check_eq("t6_rst_underrun", {31'h0, underrun}, 32'h0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        run_bits(1'b0, 1'b0, 26, bits);
        check_eq("t6_rest_left_quiet", bits, 32'h0);
        slot_check("t6_right_ignored", 1'b1, 16'h0000);
        push(16'h3C5A);
        slot_check("t6_left", 1'b0, 16'h3C5A);
        slot_check("t6_right", 1'b1, 16'h3C5A);

        // T5: reset released mid right slot with a sample waiting
        run_bits(1'b1, 1'b0, 32, bits);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        run_bits(1'b1, 1'b1, 10, bits);
        @(negedge i_clk);
        i_rst_n      = 1'b1;
        smp_if.valid = 1'b1;
        smp_if.data  = 16'hC0DE;
        @(negedge i_clk);
        smp_if.valid = 1'b0;
        run_bits(1'b0, 1'b0, 22, bits);
        check_eq("t5_right_quiet", bits, 32'h0);
        slot_check("t5_left", 1'b0, 16'hC0DE);
        slot_check("t5_right", 1'b1, 16'hC0DE);
        check_eq("t5_underrun", {31'h0, underrun}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
